wired_rename_ibuf: RTL and testbench



---
 rtl/wired_pkg.sv | 35 +++
 rtl/wired_ibuf_flush_scan.sv | 33 +++
 rtl/wired_rename_ibuf.sv | 119 +++++++++++
 tb/tb_wired_rename_ibuf.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wired_pkg.sv
// Shared types and helpers for the rename-stage instruction buffer.
// Optional same-cycle bypass is enabled by defining WIRED_IBUF_BYPASS_EN.
package wired_pkg;

    localparam int IBUF_DEPTH     = 4;
    localparam int IBUF_WIDTH     = 2;
    localparam int IBUF_PKG_WIDTH = 128;
    localparam int IBUF_TID_WIDTH = 1;

    typedef struct packed {
        logic [IBUF_WIDTH-1:0]                mask;
        logic [IBUF_TID_WIDTH-1:0]            tid;
        logic [IBUF_WIDTH*IBUF_PKG_WIDTH-1:0] payload;
    } ibuf_entry_t;

    // True when the accepted valid lanes form an in-order prefix of mask.
    function automatic logic lane_prefix_ok(
        input logic [3:0] mask,
        input logic [3:0] accept
    );
        logic seen_pending;
        logic ok;
        seen_pending = 1'b0;
        ok           = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && !accept[i]) begin
                seen_pending = 1'b1;
            end else if (mask[i] && accept[i] && seen_pending) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/wired_ibuf_flush_scan.sv
// Finds the oldest entry of the redirected stream and counts survivors.
// Used by wired_rename_ibuf (WIRED_IBUF_BYPASS_EN has no effect here).
module wired_ibuf_flush_scan #(
    parameter int DEPTH     = 4,
    parameter int TID_WIDTH = 1,
    parameter int PW        = 2,
    parameter int CW        = 3
) (
    input  logic [PW-1:0]                      head,
    input  logic [CW-1:0]                      count,
    input  logic [DEPTH-1:0][TID_WIDTH-1:0]    tids,
    input  logic [TID_WIDTH-1:0]               flush_tid,
    output logic [PW-1:0]                      first,
    output logic [CW-1:0]                      survivors
);

    logic [PW-1:0] idx;

    // Walk newest to oldest so the last hit is the oldest survivor.
    always_comb begin
        first     = head + count[PW-1:0];
        survivors = '0;
        idx       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = head + PW'(k);
            if (CW'(k) < count && tids[idx] == flush_tid) begin
                first     = idx;
                survivors = survivors + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wired_rename_ibuf.sv
// DEPTH-entry FIFO of WIDTH-lane packets feeding rename, with tid flush.
// Define WIRED_IBUF_BYPASS_EN for 0-cycle latency when the buffer is empty.
module wired_rename_ibuf
    import wired_pkg::*;
#(
    parameter int WIDTH     = IBUF_WIDTH,
    parameter int DEPTH     = IBUF_DEPTH,
    parameter int PKG_WIDTH = IBUF_PKG_WIDTH,
    parameter int TID_WIDTH = IBUF_TID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkg_valid_i,
    output logic                         pkg_ready_o,
    input  logic [WIDTH-1:0]             pkg_mask_i,
    input  logic [TID_WIDTH-1:0]         pkg_tid_i,
    input  logic [WIDTH*PKG_WIDTH-1:0]   pkg_i,
    output logic [WIDTH-1:0]             r_mask_o,
    output logic [WIDTH*PKG_WIDTH-1:0]   r_pkg_o,
    input  logic [WIDTH-1:0]             r_accept_i,
    input  logic                         flush_i,
    input  logic [TID_WIDTH-1:0]         flush_tid_i,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]                 masks [DEPTH];
    logic [WIDTH*PKG_WIDTH-1:0]       data  [DEPTH];
    logic [DEPTH-1:0][TID_WIDTH-1:0]  tids;
    logic [PW-1:0]                    head;
    logic [PW-1:0]                    tail;
    logic [CW-1:0]                    count;

    logic [WIDTH-1:0] head_mask;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] wr_mask;
    logic             hs;
    logic             push;
    logic             pop;
    logic [PW-1:0]    scan_first;
    logic [CW-1:0]    scan_surv;

    wired_ibuf_flush_scan #(
        .DEPTH     (DEPTH),
        .TID_WIDTH (TID_WIDTH),
        .PW        (PW),
        .CW        (CW)
    ) u_scan (
        .head      (head),
        .count     (count),
        .tids      (tids),
        .flush_tid (flush_tid_i),
        .first     (scan_first),
        .survivors (scan_surv)
    );

    always_comb begin
        head_mask   = masks[head];
        pkg_ready_o = count < CW'(DEPTH);
        empty_o     = count == '0;
        count_o     = count;
        hs          = pkg_valid_i && pkg_ready_o;
        r_mask_o    = (count != '0) ? head_mask : '0;
        r_pkg_o     = data[head];
        wr_mask     = pkg_mask_i;
`ifdef WIRED_IBUF_BYPASS_EN
        // Empty buffer: rename sees the packet now, only leftovers are stored.
        if (count == '0 && !flush_i && pkg_valid_i) begin
            r_mask_o = pkg_mask_i;
            r_pkg_o  = pkg_i;
            wr_mask  = pkg_mask_i & ~r_accept_i;
        end
`endif
        push = hs && (wr_mask != '0)
            && (!flush_i || pkg_tid_i == flush_tid_i);
        rem  = head_mask & ~r_accept_i;
        pop  = !flush_i && (count != '0) && (rem == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                masks[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                head  <= scan_first;
                count <= scan_surv + CW'(push);
            end else begin
                if (count != '0) begin
                    masks[head] <= rem;
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
            if (push) begin
                masks[tail] <= wr_mask;
                tids[tail]  <= pkg_tid_i;
                data[tail]  <= pkg_i;
                tail        <= tail + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            assert (lane_prefix_ok(4'(r_mask_o), 4'(r_accept_i)));
        end
    end

endmodule

// File: tb/tb_wired_rename_ibuf.sv
// Randomised and directed bench for wired_rename_ibuf with a queue model.
// Bypass expectations follow WIRED_IBUF_BYPASS_EN when it is defined.
module tb_wired_rename_ibuf;
    import wired_pkg::*;

    localparam int W  = IBUF_WIDTH;
    localparam int D  = IBUF_DEPTH;
    localparam int PB = IBUF_WIDTH * IBUF_PKG_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pkg_valid_i = 1'b0;
    logic          pkg_ready_o;
    logic [W-1:0]  pkg_mask_i = '0;
    logic          pkg_tid_i = 1'b0;
    logic [PB-1:0] pkg_i = '0;
    logic [W-1:0]  r_mask_o;
    logic [PB-1:0] r_pkg_o;
    logic [W-1:0]  r_accept_i = '0;
    logic          flush_i = 1'b0;
    logic          flush_tid_i = 1'b0;
    logic          empty_o;
    logic [2:0]    count_o;

    int n_tests = 0;
    int n_fail  = 0;

    ibuf_entry_t q[$];

    wired_rename_ibuf dut (
        .clk         (clk),
        .rst         (rst),
        .pkg_valid_i (pkg_valid_i),
        .pkg_ready_o (pkg_ready_o),
        .pkg_mask_i  (pkg_mask_i),
        .pkg_tid_i   (pkg_tid_i),
        .pkg_i       (pkg_i),
        .r_mask_o    (r_mask_o),
        .r_pkg_o     (r_pkg_o),
        .r_accept_i  (r_accept_i),
        .flush_i     (flush_i),
        .flush_tid_i (flush_tid_i),
        .empty_o     (empty_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PB-1:0] pl(input int i);
        return {8{32'(i)}};
    endfunction

    function automatic logic [W-1:0] exp_rmask();
        if (q.size() == 0) begin
`ifdef WIRED_IBUF_BYPASS_EN
            if (pkg_valid_i && !flush_i) return pkg_mask_i;
`endif
            return '0;
        end
        return q[0].mask;
    endfunction

    function automatic logic [PB-1:0] exp_rpkg();
        if (q.size() == 0) return pkg_i;
        return q[0].payload;
    endfunction

    // Apply the buffer rules to the queue for the inputs now driven.
    function automatic void model_step();
        ibuf_entry_t e;
        ibuf_entry_t s[$];
        bit          hs;
        e.mask    = pkg_mask_i;
        e.tid     = pkg_tid_i;
        e.payload = pkg_i;
        hs = pkg_valid_i && (q.size() < D);
        if (rst) begin
            q.delete();
        end else if (flush_i) begin
            foreach (q[i]) if (q[i].tid == flush_tid_i) s.push_back(q[i]);
            q = s;
            if (hs && e.mask != 0 && e.tid == flush_tid_i) q.push_back(e);
        end else begin
            if (q.size() > 0) begin
                q[0].mask = q[0].mask & ~r_accept_i;
                if (q[0].mask == 0) void'(q.pop_front());
            end else begin
`ifdef WIRED_IBUF_BYPASS_EN
                if (hs) e.mask = e.mask & ~r_accept_i;
`endif
            end
            if (hs && e.mask != 0) q.push_back(e);
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(
        input logic          v,
        input logic [W-1:0]  m,
        input logic          t,
        input logic [PB-1:0] p,
        input logic [W-1:0]  a,
        input logic          f,
        input logic          ft
    );
        pkg_valid_i = v;
        pkg_mask_i  = m;
        pkg_tid_i   = t;
        pkg_i       = p;
        r_accept_i  = a;
        flush_i     = f;
        flush_tid_i = ft;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, '0, 0, '0, '0, 0, 0);
        tick();
        rst = 1'b0;
        drive(0, '0, 0, '0, '0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (pkg_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", pkg_ready_o);
        end
        n_tests++;
        if (r_mask_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rmask got %b want 00", r_mask_o);
        end
        n_tests++;
        if (empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_empty got %b want 1", empty_o);
        end
        n_tests++;
        if (count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d want 0", count_o);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(1, 2'b11, 0, pl(i), '0, 0, 0);
            n_tests++;
            if (pkg_ready_o !== 1'b1 || count_o !== 3'(i)) begin
                n_fail++;
                $display("FAIL fill_%0d ready=%b count=%0d want 1/%0d",
                         i, pkg_ready_o, count_o, i);
            end
            tick();
        end
        drive(1, 2'b11, 0, pl(9), '0, 0, 0);
        n_tests++;
        if (pkg_ready_o !== 1'b0 || count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL fill_full ready=%b count=%0d want 0/4",
                     pkg_ready_o, count_o);
        end
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (count_o !== 3'd4 || r_pkg_o !== pl(0)) begin
            n_fail++;
            $display("FAIL fill_refused count=%0d head=%h want 4/%h",
                     count_o, r_pkg_o[31:0], 32'd0);
        end
    endtask

    task automatic test_partial();
        drive(0, '0, 0, '0, 2'b01, 0, 0);
        n_tests++;
        if (r_mask_o !== 2'b11) begin
            n_fail++;
            $display("FAIL partial_pre got %b want 11", r_mask_o);
        end
        tick();
        drive(0, '0, 0, '0, 2'b10, 0, 0);
        n_tests++;
        if (r_mask_o !== 2'b10 || r_pkg_o !== pl(0) || count_o !== 3'd4) begin
            n_fail++;
            $display("FAIL partial_half mask=%b count=%0d want 10/4",
                     r_mask_o, count_o);
        end
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (count_o !== 3'd3 || r_pkg_o !== pl(1) || r_mask_o !== 2'b11) begin
            n_fail++;
            $display("FAIL partial_pop count=%0d mask=%b want 3/11",
                     count_o, r_mask_o);
        end
    endtask

    task automatic push_tids(input int n, input logic [3:0] t, input int base);
        logic [3:0] tv;
        tv = t;
        for (int i = 0; i < n; i++) begin
            drive(1, 2'b11, tv[i], pl(base + i), '0, 0, 0);
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        push_tids(4, 4'b1100, 10);
        drive(0, '0, 0, '0, 2'b11, 1, 1);
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (count_o !== 3'd2 || r_pkg_o !== pl(12) || r_mask_o !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_keep count=%0d head=%h want 2/%h",
                     count_o, r_pkg_o[31:0], 32'd12);
        end
        do_reset();
        push_tids(3, 4'b0110, 20);
        drive(1, 2'b11, 0, pl(23), '0, 1, 1);
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (count_o !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_push_stale count=%0d want 2", count_o);
        end
        do_reset();
        push_tids(3, 4'b0110, 30);
        drive(1, 2'b11, 1, pl(33), '0, 1, 1);
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (count_o !== 3'd3 || r_pkg_o !== pl(31)) begin
            n_fail++;
            $display("FAIL flush_push_live count=%0d want 3", count_o);
        end
        do_reset();
        push_tids(4, 4'b0000, 40);
        drive(0, '0, 0, '0, '0, 1, 1);
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (empty_o !== 1'b1 || r_mask_o !== 2'b00 || pkg_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_all empty=%b mask=%b ready=%b want 1/00/1",
                     empty_o, r_mask_o, pkg_ready_o);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        push_tids(4, 4'b0000, 50);
        drive(1, 2'b11, 0, pl(54), 2'b11, 0, 0);
        n_tests++;
        if (pkg_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_ready got %b want 0", pkg_ready_o);
        end
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (count_o !== 3'd3) begin
            n_fail++;
            $display("FAIL fullpop_count got %0d want 3", count_o);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, 0, '0, 2'b11, 0, 0);
            n_tests++;
            if (r_pkg_o !== pl(51 + k) || r_mask_o !== 2'b11) begin
                n_fail++;
                $display("FAIL fullpop_order_%0d got %h want %h",
                         k, r_pkg_o[31:0], 32'(51 + k));
            end
            tick();
        end
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpop_drain empty=%b want 1", empty_o);
        end
    endtask

    task automatic test_wrap();
        int sent;
        int got;
        int k;
        logic [W-1:0] em;
        do_reset();
        sent = 0;
        got  = 0;
        for (int c = 0; c < 200 && (sent < 3 * D + 2 || q.size() != 0); c++) begin
            k = $urandom_range(0, 2);
            drive(sent < 3 * D + 2, 2'b11, 0, pl(100 + sent),
                  2'((1 << k) - 1), 0, 0);
            em = exp_rmask();
            if (em != 0) begin
                n_tests++;
                if (r_pkg_o !== pl(100 + got)) begin
                    n_fail++;
                    $display("FAIL wrap_order got %h want %h",
                             r_pkg_o[31:0], 32'(100 + got));
                end
            end
            if (q.size() != 0 && (q[0].mask & ~2'((1 << k) - 1)) == 0) got++;
            if (pkg_valid_i && q.size() < D) sent++;
            tick();
        end
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (count_o !== 3'd0 || got != 3 * D + 2) begin
            n_fail++;
            $display("FAIL wrap_done count=%0d popped=%0d want 0/%0d",
                     count_o, got, 3 * D + 2);
        end
    endtask

    task automatic test_random();
        logic cur;
        logic sw;
        logic f;
        logic ft;
        logic [W-1:0] em;
        do_reset();
        cur = 1'b0;
        sw  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            f  = ($urandom_range(0, 14) == 0);
            ft = sw ? cur : 1'($urandom_range(0, 1));
            if (!f && !sw && $urandom_range(0, 9) == 0) begin
                cur = ~cur;
                sw  = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), cur,
                  {8{$urandom()}}, 2'((1 << $urandom_range(0, 2)) - 1), f, ft);
            em = exp_rmask();
            n_tests++;
            if (r_mask_o !== em) begin
                n_fail++;
                $display("FAIL rand_mask c=%0d got %b want %b", c, r_mask_o, em);
            end
            if (em != 0) begin
                n_tests++;
                if (r_pkg_o !== exp_rpkg()) begin
                    n_fail++;
                    $display("FAIL rand_pkg c=%0d got %h want %h",
                             c, r_pkg_o[31:0], exp_rpkg() & 32'hffffffff);
                end
            end
            n_tests++;
            if (count_o !== 3'(q.size()) || pkg_ready_o !== (q.size() < D)
                || empty_o !== (q.size() == 0)) begin
                n_fail++;
                $display("FAIL rand_state c=%0d count=%0d ready=%b empty=%b want %0d",
                         c, count_o, pkg_ready_o, empty_o, q.size());
            end
            tick();
            if (f) begin
                cur = ft;
                sw  = 1'b0;
            end
        end
    endtask

`ifdef WIRED_IBUF_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        drive(1, 2'b11, 0, pl(60), 2'b01, 0, 0);
        n_tests++;
        if (r_mask_o !== 2'b11 || r_pkg_o !== pl(60)) begin
            n_fail++;
            $display("FAIL bypass_now mask=%b want 11", r_mask_o);
        end
        tick();
        drive(0, '0, 0, '0, '0, 0, 0);
        n_tests++;
        if (r_mask_o !== 2'b10 || count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL bypass_rem mask=%b count=%0d want 10/1",
                     r_mask_o, count_o);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_partial();
        test_flush();
        test_full_pop();
        test_wrap();
        test_random();
`ifdef WIRED_IBUF_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
